// File: rtl/controlador_mineria_pkg.sv
// Shared definitions for controlador_mineria.
//   - Controller state encoding (2-bit).
//   - Job layout: 12 block bytes followed by 1 target byte.
package controlador_mineria_pkg;

  localparam int unsigned NUM_BYTES_BLOQUE  = 12;
  localparam int unsigned NUM_BYTES_TRABAJO = 13;
  localparam int unsigned INDICE_W          = 4;

  typedef enum logic [1:0] {
    CARGA    = 2'd0,
    ARRANQUE = 2'd1,
    MINANDO  = 2'd2,
    ENTREGA  = 2'd3
  } estado_t;

endpackage

// File: rtl/controlador_mineria_if.sv
// Job stream and result channel of controlador_mineria.
//   byte_in/byte_valid/byte_ready : byte-wide job stream (valid/ready)
//   resultado_valido/resultado_ack: result hold/acknowledge handshake
//   hash_out/ciclos_out/timeout   : result payload
// master = job producer / result consumer, slave = controller.
interface controlador_mineria_if #(
  parameter int unsigned CNT_W = 32
);
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             resultado_valido;
  logic             resultado_ack;
  logic [23:0]      hash_out;
  logic [CNT_W-1:0] ciclos_out;
  logic             timeout;

  modport master (
    output byte_in, byte_valid, resultado_ack,
    input  byte_ready, resultado_valido, hash_out, ciclos_out, timeout
  );

  modport slave (
    input  byte_in, byte_valid, resultado_ack,
    output byte_ready, resultado_valido, hash_out, ciclos_out, timeout
  );
endinterface

// File: rtl/controlador_mineria_cargador_bytes.sv
// Job byte loader: tracks the byte index and writes each accepted byte into
// the block register (byte 0 at [95:88]) or, for the 13th byte, the target.
// Ports:
//   clk, reset (async, active-low)
//   habilitado     : loader owns the stream (controller in CARGA, ready high)
//   byte_in/byte_valid : job stream
//   cancelar       : restart the job from byte 0 (written bytes are kept)
//   bloque_bytes, target : loaded job
//   carga_completa : 1-cycle pulse on the 13th accepted byte
module controlador_mineria_cargador_bytes
  import controlador_mineria_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        habilitado,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        cancelar,
  output logic [95:0] bloque_bytes,
  output logic [7:0]  target,
  output logic        carga_completa
);

  logic [INDICE_W-1:0] indice_q;
  logic [95:0]         bloque_q;
  logic [7:0]          target_q;
  logic                transferencia;

  // A cancel in the same cycle as an offered byte wins: the index restarts.
  assign transferencia  = habilitado & byte_valid & ~cancelar;
  assign carga_completa = transferencia & (indice_q == INDICE_W'(NUM_BYTES_TRABAJO - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      indice_q <= '0;
      bloque_q <= '0;
      target_q <= '0;
    end else if (habilitado && cancelar) begin
      indice_q <= '0;
    end else if (transferencia) begin
      for (int i = 0; i < int'(NUM_BYTES_BLOQUE); i++) begin
        if (indice_q == INDICE_W'(i)) begin
          bloque_q[(NUM_BYTES_BLOQUE - 1 - i) * 8 +: 8] <= byte_in;
        end
      end
      if (carga_completa) begin
        target_q <= byte_in;
        indice_q <= '0;
      end else begin
        indice_q <= indice_q + INDICE_W'(1);
      end
    end
  end

  assign bloque_bytes = bloque_q;
  assign target       = target_q;

endmodule

// File: rtl/controlador_mineria.sv
// Upstream sequencer for the hashing core: loads a 13-byte job, resets and
// starts the core, waits for terminado or MAX_CICLOS cycles, then holds the
// result until acknowledged.
// Ports:
//   clk, reset (async, active-low)
//   bus        : job stream + result channel (slave side)
//   cancelar   : abort the current job (pulse)
//   terminado, hash_in : from the core
//   bloque_bytes, target, inicio, reset_nucleo (active-low) : to the core
module controlador_mineria
  import controlador_mineria_pkg::*;
#(
  parameter int unsigned MAX_CICLOS = 1000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  controlador_mineria_if.slave bus,
  input  logic                 cancelar,
  input  logic                 terminado,
  input  logic [23:0]          hash_in,
  output logic [95:0]          bloque_bytes,
  output logic [7:0]           target,
  output logic                 inicio,
  output logic                 reset_nucleo
);

  localparam logic [CNT_W-1:0] ULTIMO  = CNT_W'(MAX_CICLOS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CICLOS);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] contador_q, contador_d;
  logic [CNT_W-1:0] ciclos_q, ciclos_d;
  logic [23:0]      hash_q, hash_d;
  logic             timeout_q, timeout_d;
  logic             valido_q, valido_d;
  logic             carga_completa;

  controlador_mineria_cargador_bytes u_cargador (
    .clk            (clk),
    .reset          (reset),
    .habilitado     (estado_q == CARGA),
    .byte_in        (bus.byte_in),
    .byte_valid     (bus.byte_valid),
    .cancelar       (cancelar),
    .bloque_bytes   (bloque_bytes),
    .target         (target),
    .carga_completa (carga_completa)
  );

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    ciclos_d   = ciclos_q;
    hash_d     = hash_q;
    timeout_d  = timeout_q;
    valido_d   = valido_q;
    unique case (estado_q)
      CARGA: begin
        if (carga_completa) estado_d = ARRANQUE;
      end
      ARRANQUE: begin
        contador_d = '0;
        timeout_d  = 1'b0;
        estado_d   = MINANDO;
      end
      MINANDO: begin
        // Saturating: never wraps even if MAX_CICLOS is near 2^CNT_W.
        if (contador_q != '1) contador_d = contador_q + CNT_W'(1);
        if (cancelar) begin
          estado_d = CARGA;
        end else if (terminado) begin
          hash_d    = hash_in;
          ciclos_d  = contador_q;
          timeout_d = 1'b0;
          valido_d  = 1'b1;
          estado_d  = ENTREGA;
        end else if (contador_q == ULTIMO) begin
          hash_d    = '0;
          ciclos_d  = MAX_CNT;
          timeout_d = 1'b1;
          valido_d  = 1'b1;
          estado_d  = ENTREGA;
        end
      end
      ENTREGA: begin
        if (bus.resultado_ack) begin
          valido_d = 1'b0;
          estado_d = CARGA;
        end
      end
      default: estado_d = CARGA;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= CARGA;
      contador_q <= '0;
      ciclos_q   <= '0;
      hash_q     <= '0;
      timeout_q  <= 1'b0;
      valido_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      ciclos_q   <= ciclos_d;
      hash_q     <= hash_d;
      timeout_q  <= timeout_d;
      valido_q   <= valido_d;
    end
  end

  // Straight decodes of the state register; the core reset is also held low
  // while the controller itself is in reset.
  assign bus.byte_ready       = (estado_q == CARGA);
  assign inicio               = (estado_q == MINANDO);
  assign reset_nucleo         = reset & (estado_q != ARRANQUE);
  assign bus.resultado_valido = valido_q;
  assign bus.hash_out         = hash_q;
  assign bus.ciclos_out       = ciclos_q;
  assign bus.timeout          = timeout_q;

endmodule

// File: doc/controlador_mineria.md
Name: controlador_mineria

Overview:
Upstream sequencer for modulo_rendimiento. It accepts a 13-byte job over a byte-wide valid/ready stream: 12 block bytes followed by 1 target byte. It drives bloque_bytes, target, inicio and a per-job core reset into the hashing core, then waits for terminado or a timeout. It then latches the result and holds it until an acknowledge, and only then accepts the next job.

Parameters:
MAX_CICLOS, 1000, maximum MINANDO cycles before timeout (must be ≥ 2)
CNT_W, 32, width of the cycle counter and of ciclos_out

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
byte_in  input  8  job byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  block accepts a byte this cycle
cancelar  input  1  abort the current job (pulse)
terminado  input  1  from modulo_rendimiento: hash meets target
hash_in  input  24  from modulo_rendimiento: latched hash
bloque_bytes  output  96  to core; byte 0 at [95:88]
target  output  8  to core
inicio  output  1  to core: run nonce search
reset_nucleo  output  1  to core reset (active-low); low for exactly 1 cycle per job
resultado_valido  output  1  result held on hash_out/ciclos_out/timeout
resultado_ack  input  1  consumer accepts the result
hash_out  output  24  captured hash (0 on timeout)
ciclos_out  output  CNT_W  MINANDO cycles spent on the job
timeout  output  1  job ended by MAX_CICLOS, not terminado

Behaviour:
- Reset (reset=0, asynchronous) sets: state=CARGA, indice=0, bloque_bytes=0, target=0, inicio=0, reset_nucleo=0, resultado_valido=0, hash_out=0, ciclos_out=0, timeout=0, internal counter=0. reset_nucleo is forced low while reset is low, so the core is also reset.
- States: CARGA → ARRANQUE → MINANDO → ENTREGA → CARGA.
- CARGA:
  - byte_ready=1 and reset_nucleo=1.
  - A transfer occurs on byte_valid & byte_ready.
  - Transfer k (k=0..11) writes bloque_bytes[(11-k)*8 +: 8]. Transfer 12 writes target.
  - indice increments per transfer. On the 13th transfer indice clears and the state goes to ARRANQUE.
  - byte_valid with ready low is ignored, with no backpressure loss.
  - cancelar in CARGA clears indice; already written bytes are kept but will be overwritten.
- ARRANQUE (1 cycle):
  - byte_ready=0, reset_nucleo=0, inicio=0, counter cleared, timeout cleared.
  - Next state is MINANDO.
- MINANDO:
  - reset_nucleo=1 and inicio=1. The counter increments each cycle.
  - If terminado=1: capture hash_out=hash_in, ciclos_out=counter, timeout=0, then go to ENTREGA.
  - Else if counter == MAX_CICLOS-1: capture hash_out=0, ciclos_out=MAX_CICLOS, timeout=1, then go to ENTREGA.
  - terminado and timeout in the same cycle: terminado wins.
  - cancelar (highest priority over both): inicio drops, no result is produced, state goes to CARGA.
  - terminado is ignored outside MINANDO.
- ENTREGA:
  - inicio=0, reset_nucleo=1, resultado_valido=1. Outputs are stable until resultado_ack=1.
  - On ack, resultado_valido drops on the next edge and the state goes to CARGA. byte_ready reasserts that same next cycle.
  - cancelar in ENTREGA is ignored.
- All outputs are registered. bloque_bytes and target are constant from ARRANQUE through ENTREGA.
- The counter saturates and never wraps. MAX_CICLOS < 2^CNT_W is required.
- Latency: from the 13th accepted byte, reset_nucleo is low on the next cycle and inicio is high the cycle after.
- From terminado sampled high, resultado_valido is high on the next cycle.

Decomposition:
- Shared package: state encoding (CARGA, ARRANQUE, MINANDO, ENTREGA as a 2-bit localparam set), NUM_BYTES_BLOQUE=12, NUM_BYTES_TRABAJO=13.
- One natural sub-module: cargador_bytes. It holds the byte index counter and the shift/write into bloque_bytes/target, and outputs a 1-cycle carga_completa pulse.
- The FSM, timeout counter and result capture stay in the top module.

Test Plan:
1. Reset mid-load, then a normal load:
   - Assert reset=0 after 5 bytes, release, send bytes 0x01..0x0C then target 0x40.
   - Expect bloque_bytes=0x0102030405060708090A0B0C and target=0x40.
   - Expect a single reset_nucleo low pulse, then inicio=1.
2. Normal completion:
   - In MINANDO, drive terminado=1 with hash_in=0x12_34_56 on counter 7.
   - Expect the next cycle resultado_valido=1, hash_out=0x123456, ciclos_out=7, timeout=0, inicio=0.
3. Timeout (MAX_CICLOS=16):
   - Never assert terminado.
   - Expect resultado_valido=1 after 16 MINANDO cycles, timeout=1, hash_out=0, ciclos_out=16.
4. Simultaneous terminado and timeout:
   - terminado=1 on the final cycle (counter 15, MAX_CICLOS=16).
   - Expect timeout=0 and hash_out=hash_in.
5. Cancel:
   - Pulse cancelar at MINANDO cycle 3.
   - Expect inicio=0 and byte_ready=1 the next cycle, with resultado_valido never asserting.
6. Hold and backpressure:
   - Keep resultado_ack=0 for 10 cycles while byte_valid=1.
   - Expect byte_ready=0 and outputs stable throughout.
   - On ack, expect resultado_valido=0 and byte_ready=1 the next cycle.
